// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I control sequencer: state
// encodings, opcode values and pc_sel / wb_sel codes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_ECALL  = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] R_TYPE       = 7'b0110011;
    localparam logic [6:0] I_TYPE_1     = 7'b0010011;  // OP-IMM
    localparam logic [6:0] I_TYPE_2     = 7'b0000011;  // LOAD
    localparam logic [6:0] S_TYPE       = 7'b0100011;
    localparam logic [6:0] B_TYPE       = 7'b1100011;
    localparam logic [6:0] U_TYPE_LUI   = 7'b0110111;
    localparam logic [6:0] U_TYPE_AUIPC = 7'b0010111;
    localparam logic [6:0] JAL          = 7'b1101111;
    localparam logic [6:0] JALR         = 7'b1100111;
    localparam logic [6:0] ECALL        = 7'b1110011;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_RS1   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {R_TYPE, I_TYPE_1, I_TYPE_2, S_TYPE, B_TYPE,
                          U_TYPE_LUI, U_TYPE_AUIPC, JAL, JALR, ECALL};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_ctrl_word_gen.sv
// Combinational control-word decode: maps state and opcode onto the
// writeback select, PC select and ALU operand selects.
module ctrl_word_gen
    import multicycle_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    output logic [1:0] wb_sel,
    output logic [1:0] pc_sel,
    output logic       alu_a_pc,
    output logic       alu_b_imm
);

    always_comb begin
        wb_sel    = WB_ALU;
        pc_sel    = PC_PLUS4;
        alu_a_pc  = 1'b0;
        alu_b_imm = 1'b0;

        // Operand selects only matter while the datapath is working on the instruction
        if (state inside {ST_EXEC, ST_MEM, ST_WB}) begin
            alu_b_imm = opcode inside {I_TYPE_1, I_TYPE_2, S_TYPE, U_TYPE_AUIPC, JALR};
            alu_a_pc  = (opcode == U_TYPE_AUIPC);
        end

        case (state)
            ST_EXEC: begin
                if (opcode == B_TYPE && branch_taken)
                    pc_sel = PC_IMM;
            end
            ST_WB: begin
                case (opcode)
                    JAL: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_IMM;
                    end
                    JALR: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_RS1;
                    end
                    U_TYPE_LUI: wb_sel = WB_IMM;
                    I_TYPE_2:   wb_sel = WB_MEM;
                    default:    wb_sel = WB_ALU;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB/ECALL/HALT).
// Optional feature macro: ECALL_WAIT_EN (SYSTEM waits for ecall_ack).
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             branch_taken,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             ecall_req,
    input  logic             ecall_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             alu_a_pc,
    output logic             alu_b_imm,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    state_t cur_state;
    state_t nxt_state;
    logic   run;
    logic   unused_inputs;

`ifdef ECALL_WAIT_EN
    assign unused_inputs = ^funct3;
`else
    assign unused_inputs = ^{funct3, ecall_ack};
`endif

    assign state = cur_state;

    always_comb begin
        nxt_state = cur_state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ecall_req = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;

        unique case (cur_state)
            ST_FETCH: begin
                // run stays low until the first edge after reset release
                imem_req = run;
                if (run && imem_ready) begin
                    ir_we     = 1'b1;
                    nxt_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!is_legal(opcode)) begin
                    nxt_state = ST_HALT;
                end else if (opcode == ECALL) begin
`ifdef ECALL_WAIT_EN
                    nxt_state = ST_ECALL;
`else
                    pc_we     = 1'b1;
                    nxt_state = ST_FETCH;
`endif
                end else begin
                    nxt_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (opcode == I_TYPE_2 || opcode == S_TYPE) begin
                    nxt_state = ST_MEM;
                end else if (opcode == B_TYPE) begin
                    pc_we     = 1'b1;
                    nxt_state = ST_FETCH;
                end else begin
                    nxt_state = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == S_TYPE);
                if (dmem_ready) begin
                    if (opcode == S_TYPE) begin
                        pc_we     = 1'b1;
                        nxt_state = ST_FETCH;
                    end else begin
                        nxt_state = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_we    = 1'b1;
                pc_we     = 1'b1;
                nxt_state = ST_FETCH;
            end
            ST_ECALL: begin
`ifdef ECALL_WAIT_EN
                ecall_req = 1'b1;
                if (ecall_ack) begin
                    pc_we     = 1'b1;
                    nxt_state = ST_FETCH;
                end
`else
                nxt_state = ST_FETCH;
`endif
            end
            ST_HALT: nxt_state = ST_HALT;
            default: nxt_state = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_FETCH;
            run       <= 1'b0;
            illegal   <= 1'b0;
            instret   <= '0;
        end else begin
            cur_state <= nxt_state;
            run       <= 1'b1;
            if (cur_state == ST_DECODE && nxt_state == ST_HALT)
                illegal <= 1'b1;
            if (pc_we)
                instret <= instret + 1'b1;
        end
    end

    ctrl_word_gen u_ctrl_word_gen (
        .state        (cur_state),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .wb_sel       (wb_sel),
        .pc_sel       (pc_sel),
        .alu_a_pc     (alu_a_pc),
        .alu_b_imm    (alu_b_imm)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded into
// its expected per-cycle schedule from latency/handshake rules, then replayed.
module tb_multicycle_ctrl;

    localparam int unsigned CNT_W = 8;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYS    = 7'b1110011;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [6:0]       opcode = '0;
    logic [2:0]       funct3 = '0;
    logic             branch_taken = 1'b0;
    logic             imem_ready = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             ecall_ack = 1'b0;
    logic             imem_req, dmem_req, dmem_we, ecall_req;
    logic             ir_we, pc_we, reg_we, alu_a_pc, alu_b_imm, illegal;
    logic [1:0]       pc_sel, wb_sel;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .funct3       (funct3),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .ecall_req    (ecall_req),
        .ecall_ack    (ecall_ack),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .alu_a_pc     (alu_a_pc),
        .alu_b_imm    (alu_b_imm),
        .illegal      (illegal),
        .state        (state),
        .instret      (instret)
    );

    typedef struct {
        logic [6:0] op;
        logic       ir_rdy, dm_rdy, ack, taken;
        int         st;
        logic       imem_req, dmem_req, dmem_we, ecall_req;
        logic       ir_we, pc_we, reg_we;
        logic [1:0] pc_sel, wb_sel;
        logic       a_pc, b_imm, chk_alu, illegal;
    } cyc_t;

    cyc_t             q[$];
    logic [CNT_W-1:0] inst_model;
    int               errors = 0;
    int               checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic legal_op(input logic [6:0] op);
        return op inside {OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                          OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYS};
    endfunction

    // Idle handshake inputs are randomised: they must be ignored when not requesting.
    function automatic cyc_t blank(input int st, input logic [6:0] op);
        cyc_t c;
        c = '{default: '0};
        c.st     = st;
        c.op     = op;
        c.ir_rdy = 1'($urandom);
        c.dm_rdy = 1'($urandom);
        c.ack    = 1'($urandom);
        c.taken  = 1'($urandom);
        return c;
    endfunction

    function automatic cyc_t with_alu(input cyc_t ci);
        cyc_t c = ci;
        c.chk_alu = 1'b1;
        c.b_imm   = c.op inside {OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JALR};
        c.a_pc    = (c.op == OPC_AUIPC);
        return c;
    endfunction

    task automatic plan(input logic [6:0] op, input int wi, input int wd,
                        input int we, input logic taken);
        cyc_t c;
        for (int i = 0; i < wi; i++) begin
            c = blank(0, 7'($urandom));
            c.ir_rdy = 1'b0; c.imem_req = 1'b1;
            q.push_back(c);
        end
        c = blank(0, 7'($urandom));
        c.ir_rdy = 1'b1; c.imem_req = 1'b1; c.ir_we = 1'b1;
        q.push_back(c);

        c = blank(1, op);
        if (!legal_op(op)) begin
            q.push_back(c);
            for (int i = 0; i < 20; i++) begin
                c = blank(6, op);
                c.illegal = 1'b1;
                q.push_back(c);
            end
            return;
        end
        if (op == OPC_SYS) begin
`ifdef ECALL_WAIT_EN
            q.push_back(c);
            for (int i = 0; i < we; i++) begin
                c = blank(5, op);
                c.ack = 1'b0; c.ecall_req = 1'b1;
                q.push_back(c);
            end
            c = blank(5, op);
            c.ack = 1'b1; c.ecall_req = 1'b1; c.pc_we = 1'b1; c.pc_sel = 2'b00;
            q.push_back(c);
`else
            c.pc_we = 1'b1; c.pc_sel = 2'b00;
            q.push_back(c);
`endif
            return;
        end
        q.push_back(c);

        c = with_alu(blank(2, op));
        if (op == OPC_BRANCH) begin
            c.taken = taken; c.pc_we = 1'b1; c.pc_sel = taken ? 2'b01 : 2'b00;
            q.push_back(c);
            return;
        end
        q.push_back(c);

        if (op == OPC_LOAD || op == OPC_STORE) begin
            for (int i = 0; i <= wd; i++) begin
                c = with_alu(blank(3, op));
                c.dmem_req = 1'b1;
                c.dmem_we  = (op == OPC_STORE);
                c.dm_rdy   = (i == wd);
                if (i == wd && op == OPC_STORE) begin
                    c.pc_we = 1'b1; c.pc_sel = 2'b00;
                end
                q.push_back(c);
            end
            if (op == OPC_STORE) return;
        end

        c = with_alu(blank(4, op));
        c.reg_we = 1'b1; c.pc_we = 1'b1;
        case (op)
            OPC_JAL:  begin c.wb_sel = 2'b10; c.pc_sel = 2'b01; end
            OPC_JALR: begin c.wb_sel = 2'b10; c.pc_sel = 2'b10; end
            OPC_LUI:  c.wb_sel = 2'b11;
            OPC_LOAD: c.wb_sel = 2'b01;
            default:  c.wb_sel = 2'b00;
        endcase
        q.push_back(c);
    endtask

    task automatic run(input int n);
        cyc_t c;
        int   left = n;
        while (q.size() > 0 && left > 0) begin
            c = q.pop_front();
            left--;
            @(negedge clk);
            opcode       = c.op;
            funct3       = 3'($urandom);
            imem_ready   = c.ir_rdy;
            dmem_ready   = c.dm_rdy;
            ecall_ack    = c.ack;
            branch_taken = c.taken;
            #1;
            chk("state", 32'(state), 32'(c.st));
            chk("imem_req", 32'(imem_req), 32'(c.imem_req));
            chk("dmem_req", 32'(dmem_req), 32'(c.dmem_req));
            chk("dmem_we", 32'(dmem_we), 32'(c.dmem_we));
            chk("ecall_req", 32'(ecall_req), 32'(c.ecall_req));
            chk("ir_we", 32'(ir_we), 32'(c.ir_we));
            chk("pc_we", 32'(pc_we), 32'(c.pc_we));
            chk("reg_we", 32'(reg_we), 32'(c.reg_we));
            chk("illegal", 32'(illegal), 32'(c.illegal));
            chk("instret", 32'(instret), 32'(inst_model));
            if (c.pc_we)  chk("pc_sel", 32'(pc_sel), 32'(c.pc_sel));
            if (c.reg_we) chk("wb_sel", 32'(wb_sel), 32'(c.wb_sel));
            if (c.chk_alu) begin
                chk("alu_b_imm", 32'(alu_b_imm), 32'(c.b_imm));
                chk("alu_a_pc", 32'(alu_a_pc), 32'(c.a_pc));
            end
            if (c.pc_we) inst_model = inst_model + 1'b1;
        end
    endtask

    task automatic idle_check(input string name, input logic [31:0] exp);
        @(negedge clk);
        imem_ready = 1'b0; dmem_ready = 1'b0; ecall_ack = 1'b0;
        #1;
        chk(name, 32'(instret), exp);
    endtask

    task automatic reset_dut;
        @(negedge clk);
        imem_ready = 1'b0; dmem_ready = 1'b0; ecall_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_reqs", 32'({imem_req, dmem_req, dmem_we, ecall_req}), 32'd0);
        chk("rst_enables", 32'({ir_we, pc_we, reg_we}), 32'd0);
        chk("rst_sels", 32'({pc_sel, wb_sel, alu_a_pc, alu_b_imm}), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        inst_model = '0;
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        #1;
        chk("run_gate_imem_req", 32'(imem_req), 32'd0);
        chk("run_gate_ir_we", 32'(ir_we), 32'd0);
    endtask

    initial begin
        logic [6:0] ops [10];
        ops = '{OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYS};
        inst_model = '0;
        reset_dut();

        plan(OPC_OP, 0, 0, 0, 1'b0);
        chk("len_add", 32'(q.size()), 32'd4);
        run(100);
        idle_check("instret_after_add", 32'd1);

        plan(OPC_LOAD, 0, 3, 0, 1'b0);
        chk("len_lw_wait3", 32'(q.size()), 32'd8);
        run(100);

        plan(OPC_BRANCH, 0, 0, 0, 1'b1);
        chk("len_beq_taken", 32'(q.size()), 32'd3);
        run(100);
        plan(OPC_BRANCH, 0, 0, 0, 1'b0);
        run(100);

        plan(OPC_SYS, 0, 0, 4, 1'b0);
`ifdef ECALL_WAIT_EN
        chk("len_ecall_ack5", 32'(q.size()), 32'd7);
`else
        chk("len_ecall_nop", 32'(q.size()), 32'd2);
`endif
        run(100);
        idle_check("instret_after_directed", 32'd5);

        // 300 more retirements wrap the 8-bit counter: (5 + 300) mod 256 = 49
        for (int n = 0; n < 300; n++) begin
            plan(ops[$urandom_range(0, 9)], $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
            run(100);
        end
        idle_check("instret_wrapped", 32'd49);

        plan(OPC_LOAD, 0, 10, 0, 1'b0);
        run(6);
        chk("mid_mem_dmem_req", 32'(dmem_req), 32'd1);
        reset_dut();
        plan(OPC_OP, 0, 0, 0, 1'b0);
        run(100);
        idle_check("instret_after_mid_reset", 32'd1);

        plan(7'b1111111, 0, 0, 0, 1'b0);
        run(100);
        chk("halt_illegal", 32'(illegal), 32'd1);
        idle_check("instret_after_halt", 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
